adc_average_packer: RTL and testbench

Downstream consumer of the USB command interpreter's channel-select, average-points and clear-FIFO controls. Accumulates 12-bit ADC samples from two channels over a 2^(2k) window (1/4/16/64 points) and emits one tagged 16-bit average word per enabled channel into the data FIFO that feeds USB readout. Configuration is latched only at window boundaries, so host commands never corrupt a window in progress.

---
 rtl/adc_average_packer.sv | 185 ++++++++++++++++++
 tb/tb_adc_average_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_average_packer.sv
// Two-channel ADC window averager: sums 1/4/16/64 samples per enabled channel and
// emits one tagged 16-bit average word per channel into the downstream data FIFO.
module adc_average_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Channel_Select,
  input  logic [1:0]  in_set_average_points,
  input  logic        in_clear,
  input  logic        in_adc_valid,
  input  logic [11:0] in_adc_ch1,
  input  logic [11:0] in_adc_ch2,
  input  logic        in_fifo_full,
  output logic [15:0] out_data,
  output logic        out_wr_en,
  output logic        out_overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  localparam logic [1:0] ID_CH1 = 2'b01;
  localparam logic [1:0] ID_CH2 = 2'b10;

  state_t      state;
  logic [17:0] acc1;
  logic [17:0] acc2;
  logic [5:0]  count;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_avg;
  logic [11:0] hold_avg2;
  logic [1:0]  hold_code;
  logic        hold_ch2;
  logic        overrun;

  logic        window_start;
  logic [1:0]  cur_ch;
  logic [1:0]  cur_avg;
  logic [5:0]  last_idx;
  logic        sample_take;
  logic        window_end;
  logic [17:0] sum1;
  logic [17:0] sum2;
  logic [11:0] avg1;
  logic [11:0] avg2;
  logic        emitting;
  logic        fsm_free;

  // The first sample of a window sees the live controls; later samples see the latched copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    last_idx = 6'd0;
    avg1     = 12'd0;
    avg2     = 12'd0;
    fsm_free = 1'b0;

    window_start = (count == 6'd0);
    cur_ch       = window_start ? Channel_Select : cfg_ch;
    cur_avg      = window_start ? in_set_average_points : cfg_avg;
    sample_take  = in_adc_valid && (cur_ch != 2'b00);

    case (cur_avg)
      2'b00:   last_idx = 6'd0;
      2'b01:   last_idx = 6'd3;
      2'b10:   last_idx = 6'd15;
      default: last_idx = 6'd63;
    endcase
    window_end = sample_take && (count == last_idx);

    sum1 = acc1 + (cur_ch[0] ? {6'd0, in_adc_ch1} : 18'd0);
    sum2 = acc2 + (cur_ch[1] ? {6'd0, in_adc_ch2} : 18'd0);

    // Dividing by 4^k is a right shift by 2k, so pick the 12-bit slice directly.
    case (cur_avg)
      2'b00: begin
        avg1 = sum1[11:0];
        avg2 = sum2[11:0];
      end
      2'b01: begin
        avg1 = sum1[13:2];
        avg2 = sum2[13:2];
      end
      2'b10: begin
        avg1 = sum1[15:4];
        avg2 = sum2[15:4];
      end
      default: begin
        avg1 = sum1[17:6];
        avg2 = sum2[17:6];
      end
    endcase

    emitting = (state != IDLE);

    // A new result is accepted only if the emitter is idle or emitting its final word now.
    case (state)
      IDLE:    fsm_free = 1'b1;
      EMIT1:   fsm_free = !hold_ch2;
      EMIT2:   fsm_free = 1'b1;
      default: fsm_free = 1'b0;
    endcase
  end

  assign out_wr_en   = emitting && !in_fifo_full;
  assign out_overrun = overrun;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      acc1      <= 18'd0;
      acc2      <= 18'd0;
      count     <= 6'd0;
      cfg_ch    <= 2'b00;
      cfg_avg   <= 2'b00;
      hold_avg2 <= 12'd0;
      hold_code <= 2'b00;
      hold_ch2  <= 1'b0;
      overrun   <= 1'b0;
      out_data  <= 16'h0000;
    end else if (in_clear) begin
      state     <= IDLE;
      acc1      <= 18'd0;
      acc2      <= 18'd0;
      count     <= 6'd0;
      hold_avg2 <= 12'd0;
      hold_code <= 2'b00;
      hold_ch2  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emitting && in_fifo_full) begin
        overrun <= 1'b1;
      end

      if (in_adc_valid && window_start) begin
        cfg_ch  <= Channel_Select;
        cfg_avg <= in_set_average_points;
      end

      if (sample_take) begin
        if (window_end) begin
          acc1  <= 18'd0;
          acc2  <= 18'd0;
          count <= 6'd0;
        end else begin
          acc1  <= sum1;
          acc2  <= sum2;
          count <= count + 6'd1;
        end
      end

      if (window_end && fsm_free) begin
        hold_avg2 <= avg2;
        hold_code <= cur_avg;
        hold_ch2  <= cur_ch[1];
        if (cur_ch[0]) begin
          state    <= EMIT1;
          out_data <= {ID_CH1, cur_avg, avg1};
        end else begin
          state    <= EMIT2;
          out_data <= {ID_CH2, cur_avg, avg2};
        end
      end else begin
        if (window_end) begin
          overrun <= 1'b1;
        end
        case (state)
          EMIT1: begin
            if (hold_ch2) begin
              state    <= EMIT2;
              out_data <= {ID_CH2, hold_code, hold_avg2};
            end else begin
              state <= IDLE;
            end
          end
          EMIT2:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_average_packer.sv
// Self-checking bench for adc_average_packer: directed vector table, corner sequences,
// and randomized traffic against a window/schedule reference model.
module tb_adc_average_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Channel_Select;
  logic [1:0]  in_set_average_points;
  logic        in_clear;
  logic        in_adc_valid;
  logic [11:0] in_adc_ch1;
  logic [11:0] in_adc_ch2;
  logic        in_fifo_full;
  logic [15:0] out_data;
  logic        out_wr_en;
  logic        out_overrun;

  always #5 clk = ~clk;

  adc_average_packer dut (
    .clk                   (clk),
    .reset                 (reset),
    .Channel_Select        (Channel_Select),
    .in_set_average_points (in_set_average_points),
    .in_clear              (in_clear),
    .in_adc_valid          (in_adc_valid),
    .in_adc_ch1            (in_adc_ch1),
    .in_adc_ch2            (in_adc_ch2),
    .in_fifo_full          (in_fifo_full),
    .out_data              (out_data),
    .out_wr_en             (out_wr_en),
    .out_overrun           (out_overrun)
  );

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;

  // Reference model: expected FIFO writes are scheduled by absolute cycle number.
  typedef struct {
    longint      at;
    logic [15:0] word;
  } sched_t;

  sched_t      sched[$];
  longint      last_emit;
  int          m_n;
  int          m_sum1;
  int          m_sum2;
  logic [1:0]  m_ch;
  logic [1:0]  m_code;
  logic        m_ovr;
  logic [15:0] seen[$];

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  code;
    logic [11:0] s1;
    logic [11:0] s2;
    int          nwords;
    logic [15:0] w1;
    logic [15:0] w2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    last_emit = -1;
    m_n    = 0;
    m_sum1 = 0;
    m_sum2 = 0;
    m_ch   = 2'b00;
    m_code = 2'b00;
    m_ovr  = 1'b0;
  endtask

  // Checks this cycle's outputs against the model, then advances the model and the clock.
  task automatic step();
    logic        exp_wr;
    logic [15:0] exp_word;
    logic        ovr_next;
    longint      t;
    logic [11:0] a1;
    logic [11:0] a2;
    @(negedge clk);
    exp_wr   = 1'b0;
    exp_word = 16'h0000;
    ovr_next = m_ovr;
    if (sched.size() > 0 && sched[0].at == cyc) begin
      exp_word = sched[0].word;
      void'(sched.pop_front());
      if (in_fifo_full) ovr_next = 1'b1;
      else              exp_wr   = 1'b1;
    end
    check("wr_en", {31'd0, out_wr_en}, {31'd0, exp_wr});
    if (exp_wr) check("data", {16'd0, out_data}, {16'd0, exp_word});
    check("overrun", {31'd0, out_overrun}, {31'd0, m_ovr});
    if (out_wr_en === 1'b1) seen.push_back(out_data);

    if (reset) begin
      model_reset();
      ovr_next = 1'b0;
    end else if (in_clear) begin
      sched.delete();
      last_emit = -1;
      m_n      = 0;
      m_sum1   = 0;
      m_sum2   = 0;
      ovr_next = 1'b0;
    end else if (in_adc_valid) begin
      if (m_n == 0) begin
        m_ch   = Channel_Select;
        m_code = in_set_average_points;
      end
      if (m_ch != 2'b00) begin
        if (m_ch[0]) m_sum1 += int'(in_adc_ch1);
        if (m_ch[1]) m_sum2 += int'(in_adc_ch2);
        m_n++;
        if (m_n == (1 << (2 * int'(m_code)))) begin
          if (last_emit <= cyc) begin
            a1 = 12'(m_sum1 / m_n);
            a2 = 12'(m_sum2 / m_n);
            t  = cyc + 1;
            if (m_ch[0]) begin
              sched.push_back(sched_t'{t, {2'b01, m_code, a1}});
              t++;
            end
            if (m_ch[1]) begin
              sched.push_back(sched_t'{t, {2'b10, m_code, a2}});
              t++;
            end
            last_emit = t - 1;
          end else begin
            ovr_next = 1'b1;
          end
          m_n    = 0;
          m_sum1 = 0;
          m_sum2 = 0;
        end
      end
    end
    m_ovr = ovr_next;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_adc_valid = 1'b0;
    in_clear     = 1'b0;
    in_fifo_full = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    in_adc_valid = 1'b0;
    in_clear     = 1'b1;
    step();
    in_clear = 1'b0;
    seen.delete();
  endtask

  task automatic sample(input logic [11:0] s1, input logic [11:0] s2);
    in_adc_valid = 1'b1;
    in_adc_ch1   = s1;
    in_adc_ch2   = s2;
    step();
    in_adc_valid = 1'b0;
  endtask

  function automatic logic [15:0] seen_at(input int i);
    logic [15:0] w;
    w = 16'hxxxx;
    if (seen.size() > i) w = seen[i];
    return w;
  endfunction

  initial begin
    vecs[0] = '{2'b01, 2'b00, 12'h123, 12'h456, 1, 16'h4123, 16'h0000};
    vecs[1] = '{2'b10, 2'b00, 12'h777, 12'hABC, 1, 16'h8ABC, 16'h0000};
    vecs[2] = '{2'b11, 2'b01, 12'h000, 12'hFFF, 2, 16'h5000, 16'h9FFF};
    vecs[3] = '{2'b11, 2'b11, 12'hFFF, 12'h001, 2, 16'h7FFF, 16'hB001};
    vecs[4] = '{2'b01, 2'b10, 12'h800, 12'h111, 1, 16'h6800, 16'h0000};
    vecs[5] = '{2'b00, 2'b01, 12'h555, 12'h666, 0, 16'h0000, 16'h0000};

    reset                 = 1'b1;
    Channel_Select        = 2'b00;
    in_set_average_points = 2'b00;
    in_clear              = 1'b0;
    in_adc_valid          = 1'b0;
    in_adc_ch1            = 12'h000;
    in_adc_ch2            = 12'h000;
    in_fifo_full          = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {16'd0, out_data}, 32'h0000);
    check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_overrun", {31'd0, out_overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Disabled channels: no writes at all
    Channel_Select = 2'b00;
    seen.delete();
    for (int i = 0; i < 5; i++) sample(12'hABC, 12'hDEF);
    idle(4);
    check("no_ch_words", seen.size(), 32'd0);

    // Directed vector table: constant samples across one window
    foreach (vecs[v]) begin
      pulse_clear();
      Channel_Select        = vecs[v].sel;
      in_set_average_points = vecs[v].code;
      for (int i = 0; i < (1 << (2 * int'(vecs[v].code))); i++) sample(vecs[v].s1, vecs[v].s2);
      idle(4);
      check("vec_count", seen.size(), vecs[v].nwords);
      if (vecs[v].nwords >= 1) check("vec_w1", {16'd0, seen_at(0)}, {16'd0, vecs[v].w1});
      if (vecs[v].nwords >= 2) check("vec_w2", {16'd0, seen_at(1)}, {16'd0, vecs[v].w2});
    end

    // Ramp average with both channels, N = 4
    pulse_clear();
    Channel_Select        = 2'b11;
    in_set_average_points = 2'b01;
    for (int i = 0; i < 4; i++) sample(12'h100 + 12'(i), 12'hFFF);
    idle(4);
    check("ramp_count", seen.size(), 32'd2);
    check("ramp_w1", {16'd0, seen_at(0)}, 32'h5101);
    check("ramp_w2", {16'd0, seen_at(1)}, 32'h9FFF);

    // Window code change mid-window is deferred to the next window
    pulse_clear();
    Channel_Select        = 2'b01;
    in_set_average_points = 2'b10;
    for (int i = 0; i < 5; i++) sample(12'h0A5, 12'h000);
    in_set_average_points = 2'b00;
    for (int i = 0; i < 11; i++) sample(12'h0A5, 12'h000);
    idle(2);
    check("reconf_count", seen.size(), 32'd1);
    check("reconf_w1", {16'd0, seen_at(0)}, 32'h60A5);
    sample(12'h321, 12'h000);
    idle(2);
    check("reconf_w2", {16'd0, seen_at(1)}, 32'h4321);

    // FIFO full during the ch1 word
    pulse_clear();
    Channel_Select        = 2'b11;
    in_set_average_points = 2'b00;
    sample(12'h111, 12'h222);
    in_fifo_full = 1'b1;
    step();
    in_fifo_full = 1'b0;
    step();
    idle(2);
    check("full_count", seen.size(), 32'd1);
    check("full_w2", {16'd0, seen_at(0)}, 32'h8222);
    check("full_ovr_set", {31'd0, out_overrun}, 32'd1);
    pulse_clear();
    idle(1);
    check("full_ovr_clr", {31'd0, out_overrun}, 32'd0);

    // Clear mid-window discards earlier samples and a coincident valid
    Channel_Select        = 2'b01;
    in_set_average_points = 2'b01;
    sample(12'hFFF, 12'h000);
    sample(12'hFFF, 12'h000);
    in_clear     = 1'b1;
    in_adc_valid = 1'b1;
    step();
    in_clear = 1'b0;
    seen.delete();
    for (int i = 0; i < 4; i++) sample(12'h010, 12'h000);
    idle(4);
    check("clr_count", seen.size(), 32'd1);
    check("clr_w1", {16'd0, seen_at(0)}, 32'h5010);

    // Back-to-back N = 1 windows on both channels: every second result dropped
    pulse_clear();
    Channel_Select        = 2'b11;
    in_set_average_points = 2'b00;
    for (int i = 0; i < 6; i++) sample(12'h200 + 12'(i), 12'h300 + 12'(i));
    idle(3);
    check("b2b_count", seen.size(), 32'd6);
    check("b2b_w3", {16'd0, seen_at(2)}, 32'h4202);
    check("b2b_ovr", {31'd0, out_overrun}, 32'd1);

    // Randomized traffic against the reference model
    pulse_clear();
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 599) == 0);
      in_clear     = ($urandom_range(0, 99) == 0);
      in_adc_valid = ($urandom_range(0, 1) == 1);
      in_fifo_full = ($urandom_range(0, 4) == 0);
      in_adc_ch1   = 12'($urandom);
      in_adc_ch2   = 12'($urandom);
      if ($urandom_range(0, 15) == 0) Channel_Select = 2'($urandom);
      if ($urandom_range(0, 15) == 0) in_set_average_points = 2'($urandom_range(0, 3) == 3 ? 2 : $urandom_range(0, 1));
      step();
    end
    reset = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
